// File: rtl/muxn_pkg.sv
// Shared defaults and the channel-index width helper for the round-robin
// N-channel valid/ready multiplexer (muxn_rr).
package muxn_pkg;

    localparam int MUXN_NUM_CH_DEF     = 4;
    localparam int MUXN_DATA_WIDTH_DEF = 8;

    // A single channel still needs a 1-bit index so ports never collapse to zero width.
    function automatic int calc_ch_w(input int num_ch);
        int w_s;
        if (num_ch <= 1) begin
            w_s = 1;
        end else begin
            w_s = $clog2(num_ch);
        end
        return w_s;
    endfunction

endpackage

// File: rtl/muxn_rr_arbiter.sv
// Combinational circular priority search: picks the valid channel closest
// to ptr going upward with wrap, returning a one-hot grant and its index.
module muxn_rr_arbiter
    import muxn_pkg::*;
#(
    parameter int NUM_CH = MUXN_NUM_CH_DEF,
    parameter int CH_W   = calc_ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] valid_in,
    input  logic [CH_W-1:0]   ptr,
    input  logic              enable,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_vld
);

    logic [CH_W:0]   dist_s;
    logic [CH_W:0]   best_s;
    logic [CH_W-1:0] idx_s;
    logic            found_s;

    // Distance from ptr measured modulo NUM_CH; smallest distance among valid channels wins.
    always_comb begin
        dist_s  = '0;
        best_s  = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((CH_W+1)'(i) >= {1'b0, ptr}) begin
                dist_s = (CH_W+1)'(i) - {1'b0, ptr};
            end else begin
                dist_s = (CH_W+1)'(i) + (CH_W+1)'(NUM_CH) - {1'b0, ptr};
            end
            if (valid_in[i] && (!found_s || (dist_s < best_s))) begin
                found_s = 1'b1;
                best_s  = dist_s;
                idx_s   = CH_W'(i);
            end else begin
                found_s = found_s;
                best_s  = best_s;
                idx_s   = idx_s;
            end
        end
    end

    // One-hot expansion of the winner, suppressed when the output stage cannot load.
    always_comb begin
        grant_vld = found_s && enable;
        grant_idx = idx_s;
        grant     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            grant[i] = grant_vld && (idx_s == CH_W'(i));
        end
    end

endmodule

// File: rtl/muxn_rr.sv
// Round-robin N:1 valid/ready multiplexer with a registered output stage.
// Define MUXN_CH_ID_EN to add the ch_out source-channel port and register.
module muxn_rr
    import muxn_pkg::*;
#(
    parameter int NUM_CH     = MUXN_NUM_CH_DEF,
    parameter int DATA_WIDTH = MUXN_DATA_WIDTH_DEF,
    parameter int CH_W       = calc_ch_w(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            valid_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    output logic [NUM_CH-1:0]            pop_in,
    input  logic                         ready_out,
    output logic                         valid_out,
    output logic [DATA_WIDTH-1:0]        data_out
`ifdef MUXN_CH_ID_EN
    ,
    output logic [CH_W-1:0]              ch_out
`endif
);

    logic                  load_s;
    logic                  arb_en_s;
    logic [NUM_CH-1:0]     grant_s;
    logic [CH_W-1:0]       grant_idx_s;
    logic                  grant_vld_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [CH_W-1:0]       ptr_nxt_s;
    logic [CH_W-1:0]       ptr_r;

    // Load when the output register is empty or its word leaves this cycle; never pop during reset.
    assign load_s   = !valid_out || ready_out;
    assign arb_en_s = load_s && !reset;
    assign pop_in   = grant_s;

    muxn_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arbiter (
        .valid_in  (valid_in),
        .ptr       (ptr_r),
        .enable    (arb_en_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_vld (grant_vld_s)
    );

    // Select the granted word with the one-hot grant so pop_in has no path from data_in.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_s[i]) begin
                sel_data_s = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Pointer moves just past the winner, wrapping explicitly for non-power-of-two NUM_CH.
    always_comb begin
        if (grant_idx_s == CH_W'(NUM_CH - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = grant_idx_s + CH_W'(1);
        end
    end

    // Output stage and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            ptr_r     <= '0;
        end else if (load_s) begin
            if (grant_vld_s) begin
                valid_out <= 1'b1;
                data_out  <= sel_data_s;
                ptr_r     <= ptr_nxt_s;
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

`ifdef MUXN_CH_ID_EN
    // Source channel tag travels with the word it describes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_out <= '0;
        end else if (load_s && grant_vld_s) begin
            ch_out <= grant_idx_s;
        end
    end
`endif

endmodule

// File: tb/tb_muxn_rr.sv
// Scoreboard bench for muxn_rr: per-channel source queues feed the DUT, a
// reference arbiter predicts pops and output words, a monitor checks outputs.
module tb_muxn_rr;
    import muxn_pkg::*;

`ifdef MUXN_CH_ID_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 4;
`endif
    localparam int DW  = 8;
    localparam int CHW = calc_ch_w(NCH);

    typedef struct {
        logic [DW-1:0] data;
        int            ch;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NCH-1:0]    valid_in = '0;
    logic [NCH*DW-1:0] data_in = '0;
    logic [NCH-1:0]    pop_in;
    logic              ready_out = 1'b0;
    logic              valid_out;
    logic [DW-1:0]     data_out;
`ifdef MUXN_CH_ID_EN
    logic [CHW-1:0]    ch_out;
`endif

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] src_q [NCH][$];
    exp_t          sb[$];
    int            mdl_ptr = 0;
    bit            mdl_full = 1'b0;

    muxn_rr #(.NUM_CH(NCH), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .pop_in    (pop_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out)
`ifdef MUXN_CH_ID_EN
        ,
        .ch_out    (ch_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive sources at negedge, predict the grant, check pop_in.
    task automatic cycle(input bit rdy);
        logic [NCH-1:0] exp_pop;
        int             g;
        exp_t           e;
        @(negedge clk);
        ready_out = rdy;
        for (int i = 0; i < NCH; i++) begin
            valid_in[i] = (src_q[i].size() != 0);
            if (src_q[i].size() != 0) data_in[i*DW +: DW] = src_q[i][0];
            else                      data_in[i*DW +: DW] = DW'($urandom);
        end
        #1;
        exp_pop = '0;
        g = -1;
        if (!mdl_full || rdy) begin
            for (int k = 0; k < NCH; k++) begin
                if (g < 0 && src_q[(mdl_ptr + k) % NCH].size() != 0) g = (mdl_ptr + k) % NCH;
            end
            if (g >= 0) begin
                exp_pop[g] = 1'b1;
                e.data = src_q[g].pop_front();
                e.ch   = g;
                sb.push_back(e);
                mdl_ptr  = (g + 1) % NCH;
                mdl_full = 1'b1;
            end else begin
                mdl_full = 1'b0;
            end
        end
        check("pop_in", 64'(pop_in), 64'(exp_pop));
    endtask

    task automatic do_reset_midrun();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_pop_in", 64'(pop_in), 64'd0);
`ifdef MUXN_CH_ID_EN
        check("rst_ch_out", 64'(ch_out), 64'd0);
`endif
        valid_in = '0;
        for (int i = 0; i < NCH; i++) src_q[i].delete();
        sb.delete();
        mdl_ptr  = 0;
        mdl_full = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: after each edge, a newly predicted word must appear; otherwise hold or idle.
    initial begin
        bit            mon_full;
        logic [DW-1:0] last_data;
        int            last_ch;
        exp_t          e;
        mon_full  = 1'b0;
        last_data = '0;
        last_ch   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mon_full  = 1'b0;
                last_data = '0;
                last_ch   = 0;
            end else if (sb.size() != 0) begin
                e = sb.pop_front();
                check("new_valid", 64'(valid_out), 64'd1);
                check("new_data", 64'(data_out), 64'(e.data));
`ifdef MUXN_CH_ID_EN
                check("new_ch", 64'(ch_out), 64'(e.ch));
`endif
                last_data = e.data;
                last_ch   = e.ch;
                mon_full  = 1'b1;
            end else if (mon_full && !ready_out) begin
                check("hold_valid", 64'(valid_out), 64'd1);
                check("hold_data", 64'(data_out), 64'(last_data));
            end else begin
                check("idle_valid", 64'(valid_out), 64'd0);
                check("idle_data", 64'(data_out), 64'(last_data));
`ifdef MUXN_CH_ID_EN
                check("idle_ch", 64'(ch_out), 64'(last_ch));
`endif
                mon_full = 1'b0;
            end
        end
    end

    initial begin
        #1 reset = 1'b1;
        #1;
        check("init_valid_out", 64'(valid_out), 64'd0);
        check("init_data_out", 64'(data_out), 64'd0);
        check("init_pop_in", 64'(pop_in), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // All channels continuously valid: fair rotation starting at channel 0.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NCH; i++) src_q[i].push_back(DW'(8'hA0 + i));
        for (int c = 0; c < 2*NCH + 2; c++) cycle(1'b1);

        // Only the top channel, then the two lowest: pointer wraps to 0.
        src_q[NCH-1].push_back(8'h3C);
        cycle(1'b1);
        src_q[0].push_back(8'h10);
        src_q[1].push_back(8'h11);
        for (int c = 0; c < 4; c++) cycle(1'b1);

        // Reset while a word is stalled in the output register.
        for (int i = 0; i < NCH; i++) src_q[i].push_back(DW'(8'hB0 + i));
        cycle(1'b1);
        cycle(1'b0);
        check("pre_rst_valid", 64'(valid_out), 64'd1);
        do_reset_midrun();

        // First grant after reset must be channel 0.
        for (int i = 0; i < NCH; i++) src_q[i].push_back(DW'(8'hC0 + i));
        cycle(1'b1);
        check("post_rst_pop_ch0", 64'(pop_in), 64'd1);
        for (int c = 0; c < NCH + 2; c++) cycle(1'b1);

        // Backpressure on a ch2 word; ch0 waits and is granted when ready returns.
        src_q[2].push_back(8'h55);
        cycle(1'b1);
        src_q[0].push_back(8'h66);
        for (int c = 0; c < 3; c++) cycle(1'b0);
        for (int c = 0; c < 3; c++) cycle(1'b1);

        // Randomized traffic and backpressure.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(2) == 0 && src_q[i].size() < 3) src_q[i].push_back(DW'($urandom));
            cycle($urandom_range(3) != 0);
        end

        for (int c = 0; c < 4*NCH + 4; c++) cycle(1'b1);
        @(posedge clk);
        #2;
        check("sb_drained", 64'(sb.size()), 64'd0);
        for (int i = 0; i < NCH; i++) check("src_drained", 64'(src_q[i].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
